// File: rtl/riscv_mem_dump.sv
// Memory dump engine: reads a contiguous range of 64-bit words through a
// dedicated read port and streams them out byte by byte, little-endian.
module riscv_mem_dump #(
  parameter int XLEN    = 64,
  parameter int DEPTH_W = 13
) (
  input  logic               i_riscv_core_clk,
  input  logic               i_riscv_core_rst_n,
  input  logic               i_riscv_dump_start,
  input  logic [DEPTH_W-1:0] i_riscv_dump_base,
  input  logic [DEPTH_W:0]   i_riscv_dump_count,
  output logic               o_riscv_dump_mem_re,
  output logic [DEPTH_W-1:0] o_riscv_dump_mem_addr,
  input  logic [XLEN-1:0]    i_riscv_dump_mem_rdata,
  output logic               o_riscv_dump_tx_valid,
  output logic [7:0]         o_riscv_dump_tx_data,
  input  logic               i_riscv_dump_tx_ready,
  output logic               o_riscv_dump_busy,
  output logic               o_riscv_dump_core_hold,
  output logic               o_riscv_dump_done,
  output logic [2:0]         o_riscv_dump_dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [DEPTH_W:0]   ONE_CNT  = {{DEPTH_W{1'b0}}, 1'b1};
  localparam logic [DEPTH_W-1:0] ONE_ADDR = {{(DEPTH_W-1){1'b0}}, 1'b1};

  logic [2:0]         state_q, state_d;
  logic [DEPTH_W-1:0] addr_q, addr_d;
  logic [DEPTH_W:0]   remaining_q, remaining_d;
  logic [XLEN-1:0]    shreg_q, shreg_d;
  logic [2:0]         byte_cnt_q, byte_cnt_d;

  // tx handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
  // once tx_valid is raised, tx_valid and tx_data hold until that transfer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    shreg_d     = shreg_q;
    byte_cnt_d  = byte_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_riscv_dump_start) begin
          if (i_riscv_dump_count == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d      = i_riscv_dump_base;
            remaining_d = i_riscv_dump_count;
            state_d     = S_READ;
          end
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        shreg_d    = i_riscv_dump_mem_rdata;
        byte_cnt_d = 3'd0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (i_riscv_dump_tx_ready) begin
          shreg_d    = shreg_q >> 8;
          byte_cnt_d = byte_cnt_q + 3'd1;
          // Last byte of the word: advance to the next word index (wraps naturally).
          if (byte_cnt_q == 3'd7) begin
            remaining_d = remaining_q - ONE_CNT;
            addr_d      = addr_q + ONE_ADDR;
            state_d     = (remaining_q != ONE_CNT) ? S_READ : S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_riscv_core_clk) begin
    if (!i_riscv_core_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      shreg_q     <= '0;
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      shreg_q     <= shreg_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  assign o_riscv_dump_mem_re    = (state_q == S_READ);
  assign o_riscv_dump_mem_addr  = addr_q;
  assign o_riscv_dump_tx_valid  = (state_q == S_SEND);
  assign o_riscv_dump_tx_data   = shreg_q[7:0];
  assign o_riscv_dump_busy      = (state_q != S_IDLE);
  assign o_riscv_dump_core_hold = (state_q != S_IDLE);
  assign o_riscv_dump_done      = (state_q == S_DONE);
  assign o_riscv_dump_dbg_state = state_q;

endmodule

// File: tb/tb_riscv_mem_dump.sv
// Bench for riscv_mem_dump: memory model, output monitor, and per-scenario
// tasks compared against a byte-stream model derived from the memory contents.
module tb_riscv_mem_dump;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] base = '0;
  logic [13:0] count = '0;
  logic        mem_re;
  logic [12:0] mem_addr;
  logic [63:0] rdata = '0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        core_hold;
  logic        done;
  logic [2:0]  dbg_state;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;

  logic [63:0] mem [0:8191];

  logic [12:0] re_addr_q[$];
  int          re_cyc_q[$];
  logic [7:0]  byte_q[$];
  int          byte_cyc_q[$];
  int          done_cyc_q[$];
  int          stall_viol = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_data = '0;

  logic [7:0]  exp_q[$];
  logic [12:0] exp_addr_q[$];

  riscv_mem_dump dut (
    .i_riscv_core_clk       (clk),
    .i_riscv_core_rst_n     (rst_n),
    .i_riscv_dump_start     (start),
    .i_riscv_dump_base      (base),
    .i_riscv_dump_count     (count),
    .o_riscv_dump_mem_re    (mem_re),
    .o_riscv_dump_mem_addr  (mem_addr),
    .i_riscv_dump_mem_rdata (rdata),
    .o_riscv_dump_tx_valid  (tx_valid),
    .o_riscv_dump_tx_data   (tx_data),
    .i_riscv_dump_tx_ready  (tx_ready),
    .o_riscv_dump_busy      (busy),
    .o_riscv_dump_core_hold (core_hold),
    .o_riscv_dump_done      (done),
    .o_riscv_dump_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, fails=%0d", fails);
    $fatal(1, "watchdog");
  end

  // Synchronous memory: data appears one cycle after the read enable.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re) rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_re) begin
        re_addr_q.push_back(mem_addr);
        re_cyc_q.push_back(cyc);
      end
      if (tx_valid && tx_ready) begin
        byte_q.push_back(tx_data);
        byte_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_viol++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 0;
    end
  end

  // reference model: the bytes a dump must produce, straight from memory
  task automatic build_expected(input int b, input int n);
    logic [63:0] w;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < n; i++) begin
      w = mem[(b + i) % 8192];
      exp_addr_q.push_back(13'((b + i) % 8192));
      for (int j = 0; j < 8; j++) exp_q.push_back(8'((w >> (8 * j)) & 64'hFF));
    end
  endtask

  function automatic int byte_diffs();
    int d = (byte_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < byte_q.size() && i < exp_q.size(); i++)
      if (byte_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  function automatic int addr_diffs();
    int d = (re_addr_q.size() != exp_addr_q.size()) ? 1 : 0;
    for (int i = 0; i < re_addr_q.size() && i < exp_addr_q.size(); i++)
      if (re_addr_q[i] !== exp_addr_q[i]) d++;
    return d;
  endfunction

  // driver tasks
  task automatic clear_logs();
    re_addr_q.delete();
    re_cyc_q.delete();
    byte_q.delete();
    byte_cyc_q.delete();
    done_cyc_q.delete();
    stall_viol = 0;
  endtask

  task automatic start_dump(input logic [12:0] b, input logic [13:0] n, output int k);
    @(posedge clk);
    #1;
    start = 1'b1;
    base  = b;
    count = n;
    k     = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (done_cyc_q.size() != 0) ok = 1;
      else begin
        @(posedge clk);
        #1;
        if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      end
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [26:0] outs;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      start    = 1'($urandom_range(0, 1));
      tx_ready = 1'($urandom_range(0, 1));
      base     = 13'($urandom);
      count    = 14'($urandom_range(0, 20));
      @(negedge clk);
      outs = {mem_re, mem_addr, tx_valid, tx_data, busy, core_hold, done};
      tests_run++;
      if (outs !== 27'd0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, outs);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    tx_ready = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    int k;
    bit ok;
    int d;
    mem[0] = 64'h0807060504030201;
    clear_logs();
    tx_ready = 1'b1;
    build_expected(0, 1);
    start_dump(13'd0, 14'd1, k);
    wait_done(60, 0, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL single_timeout: got no done, expected done"); end
    tests_run++;
    if (addr_diffs() != 0 || re_cyc_q.size() != 1 || re_cyc_q[0] != k + 1) begin
      fails++;
      $display("FAIL single_mem_re: got %0d reads, expected one read of addr 0 at cycle k+1", re_addr_q.size());
    end
    tests_run++;
    if (byte_diffs() != 0) begin
      fails++;
      $display("FAIL single_bytes: got %0d bytes with %0d diffs, expected 01..08", byte_q.size(), byte_diffs());
    end
    d = (byte_cyc_q.size() != 8) ? 1 : 0;
    for (int i = 0; i < byte_cyc_q.size(); i++) if (byte_cyc_q[i] != k + 3 + i) d++;
    tests_run++;
    if (d != 0) begin fails++; $display("FAIL single_byte_timing: got %0d timing diffs, expected bytes at k+3..k+10", d); end
    tests_run++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != k + 11) begin
      fails++;
      $display("FAIL single_done_cycle: got %0d pulses (first at k+%0d), expected one at k+11",
               done_cyc_q.size(), (done_cyc_q.size() != 0) ? done_cyc_q[0] - k : -1);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || core_hold !== 1'b0 || cyc != k + 12) begin
      fails++;
      $display("FAIL single_busy_clear: got busy=%b hold=%b at k+%0d, expected 0 at k+12", busy, core_hold, cyc - k);
    end
  endtask

  task automatic test_backpressure();
    int k;
    bit ok;
    mem[5] = 64'hAABBCCDDEEFF0011;
    mem[6] = 64'h1122334455667788;
    clear_logs();
    build_expected(5, 2);
    tx_ready = 1'b0;
    start_dump(13'd5, 14'd2, k);
    wait_done(400, 1, ok);
    tests_run++;
    if (!ok || byte_diffs() != 0) begin
      fails++;
      $display("FAIL bp_bytes: got %0d bytes with %0d diffs (done=%0b), expected 16 in order", byte_q.size(), byte_diffs(), ok);
    end
    tests_run++;
    if (addr_diffs() != 0) begin
      fails++;
      $display("FAIL bp_mem_re: got %0d reads, expected addr 5 then 6", re_addr_q.size());
    end
    tests_run++;
    if (stall_viol != 0) begin fails++; $display("FAIL bp_stall_stable: got %0d violations, expected 0", stall_viol); end
    tests_run++;
    if (done_cyc_q.size() != 1) begin fails++; $display("FAIL bp_done_count: got %0d, expected 1", done_cyc_q.size()); end
  endtask

  task automatic test_zero_and_wrap();
    int k;
    bit ok;
    clear_logs();
    start_dump(13'd7, 14'd0, k);
    wait_done(10, 0, ok);
    tests_run++;
    if (!ok || done_cyc_q[0] != k + 1) begin
      fails++;
      $display("FAIL zero_done: got done=%0b at k+%0d, expected done at k+1", ok, ok ? done_cyc_q[0] - k : -1);
    end
    repeat (3) @(posedge clk);
    tests_run++;
    if (re_addr_q.size() != 0 || byte_q.size() != 0) begin
      fails++;
      $display("FAIL zero_no_traffic: got %0d reads %0d bytes, expected 0 and 0", re_addr_q.size(), byte_q.size());
    end
    mem[8191] = {$urandom, $urandom};
    mem[0]    = {$urandom, $urandom};
    clear_logs();
    build_expected(8191, 2);
    start_dump(13'd8191, 14'd2, k);
    wait_done(60, 0, ok);
    tests_run++;
    if (!ok || addr_diffs() != 0) begin
      fails++;
      $display("FAIL wrap_addr: got %0d reads (done=%0b), expected 8191 then 0", re_addr_q.size(), ok);
    end
    tests_run++;
    if (byte_diffs() != 0) begin fails++; $display("FAIL wrap_bytes: got %0d diffs, expected 0", byte_diffs()); end
  endtask

  task automatic test_start_while_busy();
    int k;
    bit ok;
    mem[0] = {$urandom, $urandom};
    clear_logs();
    build_expected(0, 1);
    tx_ready = 1'b1;
    start_dump(13'd0, 14'd1, k);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    base  = 13'd100;
    count = 14'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(60, 0, ok);
    repeat (20) @(posedge clk);
    tests_run++;
    if (!ok || byte_diffs() != 0) begin
      fails++;
      $display("FAIL busy_start_bytes: got %0d bytes with %0d diffs, expected the 8 bytes of word 0", byte_q.size(), byte_diffs());
    end
    tests_run++;
    if (done_cyc_q.size() != 1 || addr_diffs() != 0) begin
      fails++;
      $display("FAIL busy_start_ignored: got %0d done %0d reads, expected 1 and 1", done_cyc_q.size(), re_addr_q.size());
    end
  endtask

  task automatic test_reset_mid_send();
    int k;
    bit ok;
    logic [26:0] outs;
    mem[5] = {$urandom, $urandom};
    mem[6] = {$urandom, $urandom};
    clear_logs();
    tx_ready = 1'b1;
    start_dump(13'd5, 14'd2, k);
    for (int i = 0; i < 30 && byte_q.size() < 3; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    outs = {mem_re, mem_addr, tx_valid, tx_data, busy, core_hold, done};
    tests_run++;
    if (outs !== 27'd0) begin fails++; $display("FAIL midrst_outputs: got %h expected 0", outs); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (6) @(posedge clk);
    tests_run++;
    if (done_cyc_q.size() != 0 || byte_q.size() != 3) begin
      fails++;
      $display("FAIL midrst_no_done: got %0d done %0d bytes, expected 0 and 3", done_cyc_q.size(), byte_q.size());
    end
    clear_logs();
    build_expected(5, 2);
    start_dump(13'd5, 14'd2, k);
    wait_done(80, 0, ok);
    tests_run++;
    if (!ok || byte_diffs() != 0 || addr_diffs() != 0) begin
      fails++;
      $display("FAIL midrst_recover: got %0d bytes %0d diffs done=%0b, expected 16 bytes clean", byte_q.size(), byte_diffs(), ok);
    end
  endtask

  task automatic test_random_dumps();
    int k;
    bit ok;
    int b;
    int n;
    for (int t = 0; t < 4; t++) begin
      b = $urandom_range(0, 8191);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) mem[(b + i) % 8192] = {$urandom, $urandom};
      clear_logs();
      build_expected(b, n);
      start_dump(13'(b), 14'(n), k);
      wait_done(100 * n + 50, 1, ok);
      tests_run++;
      if (!ok || byte_diffs() != 0 || addr_diffs() != 0 || stall_viol != 0 || done_cyc_q.size() != 1) begin
        fails++;
        $display("FAIL random_dump base=%0d count=%0d: got %0d bytes diffs=%0d reads=%0d stall=%0d done=%0d, expected %0d bytes clean",
                 b, n, byte_q.size(), byte_diffs(), re_addr_q.size(), stall_viol, done_cyc_q.size(), exp_q.size());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    test_reset();
    test_single_word();
    test_backpressure();
    test_zero_and_wrap();
    test_start_while_busy();
    test_reset_mid_send();
    test_random_dumps();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
